// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//
// Decode-to-execute issue stage with a per-register write scoreboard.
// Every architectural register (integer bank and FP bank, selected by the
// address MSB) has a small counter of writes that have issued but not yet
// retired. An instruction is held at the input while any operand it reads,
// or the destination it writes, is still busy. Accepted instructions are
// captured into a single ID/EX output register.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready are both high. A valid that has been raised is held,
// with its payload stable, until that transfer happens. ready may depend
// combinationally on the receiver's own state and on the other side's
// inputs, but in_ready never depends on in_valid.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      decode side handshake
//   in_pc, in_instr          instruction payload
//   in_rs1, in_rs2, in_rd    register addresses (MSB = FP bank)
//   in_use_rs1, in_use_rs2   operand read flags
//   in_write_rd              destination write flag
//   wb_valid, wb_rd          writeback retiring one write to wb_rd
//   flush                    kill the ID/EX entry and block issue
//   out_valid / out_ready    EX side handshake
//   out_pc .. out_write_rd   registered copy of the accepted instruction
//   stall_cnt                saturating count of cycles with in_valid && !in_ready
//   sb_error                 sticky flag: a counter had to be clamped
module issue_scoreboard #(
  parameter int BUS_WIDTH       = 64,
  parameter int INSTR_WIDTH     = 32,
  parameter int REGFILE_LEN     = 6,
  parameter int CNT_WIDTH       = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BUS_WIDTH-1:0]       in_pc,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic [REGFILE_LEN-1:0]     in_rs1,
  input  logic [REGFILE_LEN-1:0]     in_rs2,
  input  logic [REGFILE_LEN-1:0]     in_rd,
  input  logic                       in_use_rs1,
  input  logic                       in_use_rs2,
  input  logic                       in_write_rd,
  input  logic                       wb_valid,
  input  logic [REGFILE_LEN-1:0]     wb_rd,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BUS_WIDTH-1:0]       out_pc,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [REGFILE_LEN-1:0]     out_rs1,
  output logic [REGFILE_LEN-1:0]     out_rs2,
  output logic [REGFILE_LEN-1:0]     out_rd,
  output logic                       out_write_rd,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
  output logic                       sb_error
);

  localparam int NUM_REGS = 1 << REGFILE_LEN;
  localparam int SUM_W    = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Per-register in-flight write counters. Entry 0 (integer x0) is never
  // written and therefore stays zero.
  logic [CNT_WIDTH-1:0] cnt      [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_next [NUM_REGS];
  logic                 clamp_any;

  logic rs1_busy;
  logic rs2_busy;
  logic raw_hazard;
  logic waw_block;
  logic slot_free;
  logic issue;
  logic kill;

  // A source is busy if its effective count is nonzero. A writeback to the
  // same register this cycle removes one pending write (write-first regfile
  // bypass), so a count of exactly one with a matching writeback is free.
  always_comb begin
    rs1_busy = (in_rs1 != '0) && (cnt[in_rs1] != '0) &&
               !(wb_valid && (wb_rd == in_rs1) && (cnt[in_rs1] == CNT_WIDTH'(1)));
    rs2_busy = (in_rs2 != '0) && (cnt[in_rs2] != '0) &&
               !(wb_valid && (wb_rd == in_rs2) && (cnt[in_rs2] == CNT_WIDTH'(1)));
  end

  assign raw_hazard = (in_use_rs1 && rs1_busy) || (in_use_rs2 && rs2_busy);
  // Destination saturation uses the registered count, not the bypassed one,
  // so a saturated destination only frees up the cycle after its writeback.
  assign waw_block  = in_write_rd && (in_rd != '0) && (cnt[in_rd] == CNT_MAX);
  assign slot_free  = !out_valid || out_ready;
  assign in_ready   = !flush && !raw_hazard && !waw_block && slot_free;
  assign issue      = in_valid && in_ready;
  // A flushed entry that would have written a tracked register gives its
  // reservation back.
  assign kill       = flush && out_valid && out_write_rd && (out_rd != '0);

  // Net counter update: all three deltas land in one cycle, then the result
  // is clamped into [0, CNT_MAX]. Any clamp is reported through sb_error.
  always_comb begin
    logic                 inc;
    logic                 dec_wb;
    logic                 dec_kill;
    logic [SUM_W-1:0]     up_sum;
    logic [SUM_W-1:0]     down_sum;
    logic [SUM_W-1:0]     diff;
    clamp_any = 1'b0;
    inc       = 1'b0;
    dec_wb    = 1'b0;
    dec_kill  = 1'b0;
    up_sum    = '0;
    down_sum  = '0;
    diff      = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_next[r] = '0;
      if (r != 0) begin
        inc      = issue && in_write_rd && (in_rd == r[REGFILE_LEN-1:0]);
        dec_wb   = wb_valid && (wb_rd == r[REGFILE_LEN-1:0]);
        dec_kill = kill && (out_rd == r[REGFILE_LEN-1:0]);
        up_sum   = SUM_W'(cnt[r]) + SUM_W'(inc);
        down_sum = SUM_W'(dec_wb) + SUM_W'(dec_kill);
        diff     = up_sum - down_sum;
        if (down_sum > up_sum) begin
          cnt_next[r] = '0;
          clamp_any   = 1'b1;
        end else if (diff > SUM_W'(CNT_MAX)) begin
          cnt_next[r] = CNT_MAX;
          clamp_any   = 1'b1;
        end else begin
          cnt_next[r] = diff[CNT_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_next[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_error <= 1'b0;
    end else if (clamp_any) begin
      sb_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  // ID/EX register. Flush wins over both issue (which it blocks through
  // in_ready) and consumption. Payload only changes on issue, so it stays
  // stable while the entry waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_instr    <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_write_rd <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (issue) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (issue) begin
        out_pc       <= in_pc;
        out_instr    <= in_instr;
        out_rs1      <= in_rs1;
        out_rs2      <= in_rs2;
        out_rd       <= in_rd;
        out_write_rd <= in_write_rd;
      end
    end
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Registered decode-to-execute issue stage with a per-register write scoreboard. It accepts pre-decoded instructions from decode over a valid/ready handshake and holds back any instruction whose source or destination register still has writes in flight. Issued instructions go into a single ID/EX output register. Sits between decode and the EX stage, and replaces the implicit stall-only hazard handling with an explicit in-flight counter per architectural register (integer and FP banks).

## Interface
Parameters:
- BUS_WIDTH, 64, width of PC
- INSTR_WIDTH, 32, instruction width
- REGFILE_LEN, 6, register address width; MSB selects FP bank, 2^REGFILE_LEN registers total
- CNT_WIDTH, 2, per-register in-flight counter width; max in flight = 2^CNT_WIDTH-1
- STALL_CNT_WIDTH, 16, stall statistics counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  issue accepted this cycle
- in_pc  in  BUS_WIDTH  instruction PC
- in_instr  in  INSTR_WIDTH  raw instruction
- in_rs1, in_rs2, in_rd  in  REGFILE_LEN  register addresses (bank bit included)
- in_use_rs1, in_use_rs2, in_write_rd  in  1  operand-use / destination-write flags
- wb_valid  in  1  writeback retiring a write
- wb_rd  in  REGFILE_LEN  writeback destination
- flush  in  1  kill output register contents, block issue
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  EX consumes entry
- out_pc, out_instr, out_rs1, out_rs2, out_rd, out_write_rd  out  matching widths  registered copy of accepted instruction
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of stall cycles
- sb_error  out  1  sticky scoreboard underflow/overflow flag

## Operation
- Tracked register: any address except 0 (integer x0, i.e. all-zero address). FP register {1,00000} is tracked.
- Per-register counter cnt[r].
- Effective count eff[r] = cnt[r] − (wb_valid && wb_rd==r && cnt[r]!=0). This gives same-cycle writeback bypass, matching the write-first regfile.
- raw_hazard = (in_use_rs1 && eff[rs1]!=0) || (in_use_rs2 && eff[rs2]!=0). Untracked register 0 never hazards.
- waw_block = in_write_rd && tracked(rd) && cnt[rd]==max.
- slot_free = !out_valid || out_ready.
- in_ready = !flush && !raw_hazard && !waw_block && slot_free. It is combinational.
- Issue = in_valid && in_ready. On issue, the output register loads all in_* fields and out_valid=1.
- If out_ready && out_valid and no issue, out_valid goes to 0.
- Flush: out_valid goes to 0 next cycle. If out_valid && out_write_rd && tracked(out_rd), that entry's count is decremented (kill). Flush takes priority over out_ready.
- Counter update per register, with all deltas applied in the same cycle:
  - +1 for an issue writing r
  - −1 for wb to r
  - −1 for a flush-kill of r
- Net result is clamped to [0, max]. Any clamp sets sb_error. sb_error is cleared only by reset.
- Simultaneous issue and wb to the same r: net count unchanged.
- stall_cnt increments each cycle in which in_valid && !in_ready. It saturates at all-ones.

## Timing
- Reset (async assert, sync release behaviour on next edge): all cnt=0, out_valid=0, all out_* =0, stall_cnt=0, sb_error=0. Reset mid-operation discards in-flight state without error.
- Issue latency: 1 cycle (accept at edge N, out_valid at N+1).
- Throughput: 1 instruction/cycle with out_ready held high and no hazards.
- Back-to-back dependent pair (producer issues at N, consumer needs its rd): the consumer stalls until the wb of the producer's rd is seen. Issue happens in the same cycle as that wb via the bypass.
- out_* are stable while out_valid && !out_ready && !flush.
- in_ready depends combinationally on flush, wb_valid/wb_rd and out_ready. There is no combinational path from in_valid to in_ready.

## Test plan
- Independent stream: 4 instructions rd=1..4, no sources, out_ready=1. Required: in_ready=1 every cycle, out_valid from cycle 1, cnt[1..4]=1, stall_cnt=0.
- RAW: issue rd=5, then rs1=5. Required: in_ready=0 and stall_cnt +1 per cycle until wb_valid,wb_rd=5. Consumer issues in that wb cycle, cnt[5]=0 afterwards.
- x0 handling: rd=0 write issued, then rs1=0 consumer. Required: no stall, cnt[0] stays 0. FP reg address 32 write then read: stall until wb_rd=32.
- WAW saturation (CNT_WIDTH=2): three writes to rd=7, then a fourth. Required: fourth held (in_ready=0) until one wb to 7, then it issues.
- Flush: rd=9 in output register with out_ready=0, assert flush. Required: out_valid=0 next cycle, cnt[9] back to 0, in_ready=0 during the flush cycle.
- Underflow: wb_valid,wb_rd=3 with cnt[3]=0. Required: cnt stays 0, sb_error=1 and holds until rst_n low.
